// File: rtl/Servo_PKG.sv
// Servo_PKG: servo position type shared by the servo PWM and its command sources.
package Servo_PKG;
  typedef enum logic {SERVO_POS_UP = 1'b0, SERVO_POS_DOWN = 1'b1} servo_pos_t;
endpackage

// File: rtl/motors_ctrl_pkg.sv
// motors_ctrl_pkg: FSM states, default tick constants and abs/direction helpers for motors_ctrl_responder.
package motors_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, SERVO, STEP, FINISH} state_t;
  localparam int DEF_PULSE_HIGH_TICKS = 2;
  localparam int DEF_PULSE_LOW_TICKS = 2;
  localparam int DEF_SERVO_SETTLE_TICKS = 1000;
  function automatic logic [63:0] abs_count(input logic signed [63:0] v);
    return v[63] ? 64'(-v) : 64'(v);
  endfunction
  function automatic logic dir_of(input logic signed [63:0] v);
    return v[63];
  endfunction
endpackage

// File: rtl/motors_ctrl_responder_if.sv
// motors_ctrl_responder_if: MotorsCtrl_IF request/completion handshake.
// Defining MOTORS_CTRL_ABORT_EN adds the abort request line.
interface motors_ctrl_responder_if #(parameter int PULSE_NUM_WIDTH = 16);
  logic trigger;
  logic signed [PULSE_NUM_WIDTH-1:0] pulse_num_x;
  logic signed [PULSE_NUM_WIDTH-1:0] pulse_num_y;
  Servo_PKG::servo_pos_t servo_pos;
  logic rdy;
  logic done;
`ifdef MOTORS_CTRL_ABORT_EN
  logic abort;
  modport master(output trigger, pulse_num_x, pulse_num_y, servo_pos, abort, input rdy, done);
  modport slave(input trigger, pulse_num_x, pulse_num_y, servo_pos, abort, output rdy, done);
`else
  modport master(output trigger, pulse_num_x, pulse_num_y, servo_pos, input rdy, done);
  modport slave(input trigger, pulse_num_x, pulse_num_y, servo_pos, output rdy, done);
`endif
endinterface

// File: rtl/step_axis.sv
// step_axis: per-axis remaining pulse counter and step level, paced by the shared phase strobes.
module step_axis #(parameter int W = 16) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] count,
  input  logic         tick,
  input  logic         high_phase,
  input  logic         period_end,
  output logic [W-1:0] remaining,
  output logic         step
);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      remaining <= '0;
      step <= 1'b0;
    end else if (load || clear) begin
      remaining <= load ? count : '0;
      step <= 1'b0;
    end else if (tick) begin
      step <= high_phase && remaining != '0;
      if (period_end && remaining != '0) remaining <= remaining - 1'b1;
    end
endmodule

// File: rtl/motors_ctrl_responder.sv
// motors_ctrl_responder: motors-side MotorsCtrl_IF responder driving two step/dir axes and the servo position.
// Define MOTORS_CTRL_ABORT_EN to honour the interface abort line during SERVO/STEP.
module motors_ctrl_responder
  import motors_ctrl_pkg::*, Servo_PKG::*;
#(
  parameter int PULSE_NUM_WIDTH    = 16,
  parameter int PULSE_HIGH_TICKS   = DEF_PULSE_HIGH_TICKS,
  parameter int PULSE_LOW_TICKS    = DEF_PULSE_LOW_TICKS,
  parameter int SERVO_SETTLE_TICKS = DEF_SERVO_SETTLE_TICKS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  motors_ctrl_responder_if.slave ifc,
  output logic                   step_x,
  output logic                   step_y,
  output logic                   dir_x,
  output logic                   dir_y,
  output servo_pos_t             servo_out
);
  localparam int PERIOD = PULSE_HIGH_TICKS + PULSE_LOW_TICKS;
  localparam int TW = $clog2(PERIOD + 1);
  localparam int SW = $clog2(SERVO_SETTLE_TICKS + 1);
  state_t state;
  logic [TW-1:0] phase;
  logic [SW-1:0] settle;
  servo_pos_t servo_lat;
  logic [PULSE_NUM_WIDTH-1:0] rem_x, rem_y;
  logic accept, abort_hit, tick, high_phase, period_end, moving, last, settled;
  always_comb begin
    accept = state == IDLE && ifc.rdy && ifc.trigger;
    tick = state == STEP && clk_en;
    high_phase = phase < TW'(PULSE_HIGH_TICKS);
    period_end = phase == TW'(PERIOD - 1);
    moving = rem_x != '0 || rem_y != '0;
    last = rem_x <= PULSE_NUM_WIDTH'(1) && rem_y <= PULSE_NUM_WIDTH'(1);
    settled = settle == SW'(SERVO_SETTLE_TICKS - 1);
`ifdef MOTORS_CTRL_ABORT_EN
    abort_hit = ifc.abort && (state == SERVO || state == STEP);
`else
    abort_hit = 1'b0;
`endif
  end
  step_axis #(.W(PULSE_NUM_WIDTH)) u_x (
    .clk, .reset, .load(accept), .clear(abort_hit),
    .count(PULSE_NUM_WIDTH'(abs_count(64'(ifc.pulse_num_x)))),
    .tick, .high_phase, .period_end, .remaining(rem_x), .step(step_x)
  );
  step_axis #(.W(PULSE_NUM_WIDTH)) u_y (
    .clk, .reset, .load(accept), .clear(abort_hit),
    .count(PULSE_NUM_WIDTH'(abs_count(64'(ifc.pulse_num_y)))),
    .tick, .high_phase, .period_end, .remaining(rem_y), .step(step_y)
  );
  // IDLE with rdy low is the decision cycle after acceptance, giving the 2-cycle zero-move latency
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      ifc.rdy <= 1'b1;
      ifc.done <= 1'b0;
      dir_x <= 1'b0;
      dir_y <= 1'b0;
      servo_out <= SERVO_POS_UP;
      servo_lat <= SERVO_POS_UP;
      phase <= '0;
      settle <= '0;
    end else begin
      ifc.done <= 1'b0;
      if (abort_hit) begin
        state <= FINISH;
        ifc.done <= 1'b1;
      end else
        case (state)
          IDLE:
            if (accept) begin
              ifc.rdy <= 1'b0;
              dir_x <= dir_of(64'(ifc.pulse_num_x));
              dir_y <= dir_of(64'(ifc.pulse_num_y));
              servo_lat <= ifc.servo_pos;
            end else if (!ifc.rdy) begin
              state <= servo_lat != servo_out ? SERVO : moving ? STEP : FINISH;
              ifc.done <= servo_lat == servo_out && !moving;
              servo_out <= servo_lat;
              settle <= '0;
              phase <= '0;
            end
          SERVO:
            if (clk_en) begin
              settle <= settle + 1'b1;
              if (settled) begin
                state <= moving ? STEP : FINISH;
                ifc.done <= !moving;
              end
            end
          STEP:
            if (clk_en) begin
              phase <= period_end ? '0 : phase + 1'b1;
              if (period_end && last) begin
                state <= FINISH;
                ifc.done <= 1'b1;
              end
            end
          default: begin
            state <= IDLE;
            ifc.rdy <= 1'b1;
          end
        endcase
    end
endmodule

// File: doc/motors_ctrl_responder.md
Name: motors_ctrl_responder

Overview:
Motors-side responder of the MotorsCtrl_IF handshake. It accepts a move request from an opcode handler: signed X/Y pulse counts plus a target servo position. It generates step/dir outputs for two stepper drivers and a registered servo position, then reports completion with done/rdy. It sits between the opcode-handler mux and the physical stepper/servo drivers.

Parameters:
PULSE_NUM_WIDTH, 16, width of signed pulse_num_x/pulse_num_y.
PULSE_HIGH_TICKS, 2, clk_en ticks that step stays high per pulse (>=1).
PULSE_LOW_TICKS, 2, clk_en ticks that step stays low per pulse (>=1).
SERVO_SETTLE_TICKS, 1000, clk_en ticks waited after a servo position change (>=1).

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
clk_en  in  1  tick enable; all tick counters advance only when high.
trigger  in  1  request strobe from the handler side, sampled only while rdy=1.
pulse_num_x  in  PULSE_NUM_WIDTH  signed X pulse count; sign selects direction.
pulse_num_y  in  PULSE_NUM_WIDTH  signed Y pulse count.
servo_pos  in  1  target servo position (Servo_PKG type; SERVO_POS_UP / SERVO_POS_DOWN).
rdy  out  1  idle; a request will be accepted.
done  out  1  one-clk completion pulse.
step_x, step_y  out  1  step pulses to the drivers.
dir_x, dir_y  out  1  direction; 1 = negative count.
servo_out  out  1  registered servo position driving the servo PWM.

Behaviour:
- Reset values: rdy=1, done=0, step_x=step_y=0, dir_x=dir_y=0, servo_out=SERVO_POS_UP, FSM in IDLE, all counters 0.
- States:
  - IDLE: rdy=1. On trigger (clk_en not required), latch |pulse_num_x| and |pulse_num_y| as unsigned PULSE_NUM_WIDTH remaining counts, latch dir bits and servo_pos. rdy drops the next cycle.
    - If latched servo_pos != servo_out, go to SERVO. Otherwise, if either count != 0, go to STEP. Otherwise go to FINISH.
  - SERVO: servo_out updates on entry. Count SERVO_SETTLE_TICKS clk_en ticks, then go to STEP if either count != 0, else go to FINISH.
  - STEP: each axis with remaining > 0 raises step for PULSE_HIGH_TICKS ticks, then holds it low for PULSE_LOW_TICKS ticks, then decrements remaining.
    - Both axes share the tick phase, so their pulses are aligned. An axis at 0 keeps step low.
    - Go to FINISH when both counts reach 0 at the end of a low phase.
  - FINISH: done=1 for exactly one clk cycle, then IDLE with rdy=1 on the following cycle.
- dir is stable from the acceptance cycle until FINISH; it is never changed while step is high.
- Abs value: -2^(PULSE_NUM_WIDTH-1) maps to unsigned 2^(PULSE_NUM_WIDTH-1); no overflow.
- Zero move with unchanged servo: done pulses exactly 2 clk cycles after the trigger cycle.
- trigger while rdy=0 is ignored (not queued). trigger held high across FINISH is accepted again only once rdy=1.
- clk_en low freezes all tick counters and holds step levels.
- reset mid-move: step drops immediately (async), remaining counts clear, servo_out returns to SERVO_POS_UP.

Optional Feature:
MOTORS_CTRL_ABORT_EN
- Defined: adds input abort (1 bit).
  - abort high in SERVO or STEP forces step_x/step_y low on the next clk, clears remaining counts, and goes to FINISH; done pulses as normal.
  - servo_out keeps its current value.
  - abort in IDLE or FINISH has no effect.
- Not defined: the port is absent and moves always run to completion.

Decomposition:
- Shared package motors_ctrl_pkg holds:
  - state enum (IDLE, SERVO, STEP, FINISH);
  - default tick constants;
  - abs/direction helper function.
- Servo position type stays in Servo_PKG.
- One natural sub-module, step_axis: a per-axis remaining counter and step level, driven by the shared phase strobes from the FSM. It is instantiated twice.

Test Plan:
1. Reset, then trigger with x=3, y=0, servo=UP, clk_en always 1, defaults.
   - Expect 3 step_x pulses, each 2 high + 2 low cycles; step_y stays 0; dir_x=0.
   - done pulses once; rdy returns the next cycle.
2. Trigger with x=-2, y=5.
   - Expect dir_x=1, dir_y=0; 2 step_x pulses aligned with the first 2 of 5 step_y pulses.
   - done only after the 5th y low phase.
3. Trigger with x=0, y=0, servo=DOWN, SERVO_SETTLE_TICKS=4.
   - Expect servo_out=DOWN, no steps, done after 4 ticks.
   - Then trigger with servo=DOWN and zero counts: done 2 cycles after the trigger.
4. clk_en asserted 1 in 3 cycles with x=1.
   - Step high lasts exactly 6 clk cycles.
   - A second trigger issued mid-move is ignored: exactly one done.
5. Trigger x=-32768 with PULSE_NUM_WIDTH=16.
   - The remaining counter loads 32768 and the count of step pulses matches.
   - Then assert reset mid-STEP: step_x=0, rdy=1, servo_out=UP immediately.
6. With MOTORS_CTRL_ABORT_EN, trigger x=10 and pulse abort after the 3rd pulse.
   - No further step pulses; single done; rdy=1 after.
